kf_cov_predict_2x2: RTL and testbench



---
 rtl/kf_cov_predict_2x2.sv | 188 ++++++++++++++++++
 tb/tb_kf_cov_predict_2x2.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/kf_cov_predict_2x2.sv
// Kalman covariance-predict stage: P_out = F*P*F^T + Q on signed fixed-point
// operands, time-multiplexed over a single shared multiplier (16 cycles per set).
module kf_cov_predict_2x2 #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] f00,
    input  logic signed [WIDTH-1:0] f01,
    input  logic signed [WIDTH-1:0] f10,
    input  logic signed [WIDTH-1:0] f11,
    input  logic signed [WIDTH-1:0] p00,
    input  logic signed [WIDTH-1:0] p01,
    input  logic signed [WIDTH-1:0] p10,
    input  logic signed [WIDTH-1:0] p11,
    input  logic signed [WIDTH-1:0] q00,
    input  logic signed [WIDTH-1:0] q01,
    input  logic signed [WIDTH-1:0] q10,
    input  logic signed [WIDTH-1:0] q11,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] po00,
    output logic signed [WIDTH-1:0] po01,
    output logic signed [WIDTH-1:0] po10,
    output logic signed [WIDTH-1:0] po11
);

    typedef enum logic [1:0] {
        IDLE,
        MUL_FP,
        MUL_FPFT,
        OUT
    } state_t;

    localparam int PW = 2 * WIDTH;

    state_t r_state;
    state_t w_nextState;
    logic [2:0] r_k;

    logic signed [WIDTH-1:0] r_f   [4];
    logic signed [WIDTH-1:0] r_p   [4];
    logic signed [WIDTH-1:0] r_q   [4];
    logic signed [WIDTH-1:0] r_t   [4];
    logic signed [WIDTH-1:0] r_res [3];
    logic signed [PW-1:0]    r_acc;
    logic                    r_outValid;
    logic signed [WIDTH-1:0] r_po  [4];

    logic [1:0]              w_elem;
    logic                    w_i;
    logic                    w_j;
    logic                    w_half;
    logic signed [WIDTH-1:0] w_opA;
    logic signed [WIDTH-1:0] w_opB;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW:0]      w_sum;
    logic signed [PW:0]      w_shifted;
    logic signed [WIDTH-1:0] w_dotSat;
    logic signed [WIDTH:0]   w_qSum;
    logic signed [WIDTH-1:0] w_poElem;

    // Clamp a (2*WIDTH+1)-bit value into WIDTH bits.
    function automatic logic [WIDTH-1:0] satWide(input logic [PW:0] v);
        if ((&v[PW:WIDTH-1]) || !(|v[PW:WIDTH-1]))
            return v[WIDTH-1:0];
        else if (v[PW])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    function automatic logic [WIDTH-1:0] satNarrow(input logic [WIDTH:0] v);
        if (v[WIDTH] == v[WIDTH-1])
            return v[WIDTH-1:0];
        else if (v[WIDTH])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign in_ready = (r_state == IDLE) && !rst;

    // k[2:1] selects the output element (row i, column j), k[0] the inner-product term.
    assign w_elem = r_k[2:1];
    assign w_i    = r_k[2];
    assign w_j    = r_k[1];
    assign w_half = r_k[0];

    always_comb begin
        w_opA = r_f[{w_i, w_half}];
        w_opB = r_p[{w_half, w_j}];
        if (r_state == MUL_FPFT) begin
            w_opA = r_t[{w_i, w_half}];
            w_opB = r_f[{w_j, w_half}];
        end
    end

    assign w_prod    = w_opA * w_opB;
    assign w_sum     = {r_acc[PW-1], r_acc} + {w_prod[PW-1], w_prod};
    assign w_shifted = w_sum >>> FRAC;
    assign w_dotSat  = satWide(w_shifted);
    assign w_qSum    = {w_dotSat[WIDTH-1], w_dotSat} + {r_q[w_elem][WIDTH-1], r_q[w_elem]};
    assign w_poElem  = satNarrow(w_qSum);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (in_valid) w_nextState = MUL_FP;
            MUL_FP:   if (r_k == 3'd7) w_nextState = MUL_FPFT;
            MUL_FPFT: if (r_k == 3'd7) w_nextState = OUT;
            OUT:      if (out_ready) w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= '0;
            r_acc      <= '0;
            r_outValid <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                r_f[n]  <= '0;
                r_p[n]  <= '0;
                r_q[n]  <= '0;
                r_t[n]  <= '0;
                r_po[n] <= '0;
            end
            for (int n = 0; n < 3; n++)
                r_res[n] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_k <= '0;
                    if (in_valid) begin
                        r_f[0] <= f00; r_f[1] <= f01; r_f[2] <= f10; r_f[3] <= f11;
                        r_p[0] <= p00; r_p[1] <= p01; r_p[2] <= p10; r_p[3] <= p11;
                        r_q[0] <= q00; r_q[1] <= q01; r_q[2] <= q10; r_q[3] <= q11;
                    end
                end
                MUL_FP: begin
                    r_k <= r_k + 3'd1;
                    if (!w_half)
                        r_acc <= w_prod;
                    else
                        r_t[w_elem] <= w_dotSat;
                end
                MUL_FPFT: begin
                    r_k <= r_k + 3'd1;
                    if (!w_half) begin
                        r_acc <= w_prod;
                    end else if (r_k != 3'd7) begin
                        r_res[w_elem] <= w_poElem;
                    end else begin
                        // All four results appear together so po never shows a partial set.
                        r_po[0]    <= r_res[0];
                        r_po[1]    <= r_res[1];
                        r_po[2]    <= r_res[2];
                        r_po[3]    <= w_poElem;
                        r_outValid <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready)
                        r_outValid <= 1'b0;
                end
                default: r_k <= '0;
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign po00      = r_po[0];
    assign po01      = r_po[1];
    assign po10      = r_po[2];
    assign po11      = r_po[3];

endmodule

// File: tb/tb_kf_cov_predict_2x2.sv
// Directed self-checking bench for kf_cov_predict_2x2: vector table plus
// backpressure and mid-computation reset sequences.
module tb_kf_cov_predict_2x2;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic signed [15:0] f00, f01, f10, f11;
    logic signed [15:0] p00, p01, p10, p11;
    logic signed [15:0] q00, q01, q10, q11;
    logic signed [15:0] po00, po01, po10, po11;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string           name;
        logic [3:0][15:0] f;
        logic [3:0][15:0] p;
        logic [3:0][15:0] q;
        logic [3:0][15:0] e;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    kf_cov_predict_2x2 #(.WIDTH(16), .FRAC(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .f00(f00), .f01(f01), .f10(f10), .f11(f11),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .q00(q00), .q01(q01), .q10(q10), .q11(q11),
        .out_valid(out_valid), .out_ready(out_ready),
        .po00(po00), .po01(po01), .po10(po10), .po11(po11)
    );

    // Element order 00, 01, 10, 11 maps to indices 0..3.
    function automatic logic [3:0][15:0] m4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic driveOperands(input vec_t v);
        f00 = v.f[0]; f01 = v.f[1]; f10 = v.f[2]; f11 = v.f[3];
        p00 = v.p[0]; p01 = v.p[1]; p10 = v.p[2]; p11 = v.p[3];
        q00 = v.q[0]; q01 = v.q[1]; q10 = v.q[2]; q11 = v.q[3];
    endtask

    task automatic scrambleOperands();
        f00 = 16'($urandom); f01 = 16'($urandom); f10 = 16'($urandom); f11 = 16'($urandom);
        p00 = 16'($urandom); p01 = 16'($urandom); p10 = 16'($urandom); p11 = 16'($urandom);
        q00 = 16'($urandom); q01 = 16'($urandom); q10 = 16'($urandom); q11 = 16'($urandom);
    endtask

    // Present one operand set for a single accepting edge, then count edges to out_valid.
    task automatic applyStimulus(input vec_t v, input bit waitResult, output int lat);
        @(negedge clk);
        check({v.name, " in_ready before accept"}, in_ready, 1);
        driveOperands(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scrambleOperands();
        lat = 0;
        if (waitResult) begin
            while (lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
                if (out_valid) break;
            end
            check({v.name, " latency"}, lat, 16);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0][15:0] e);
        check({name, " out_valid"}, out_valid, 1);
        check({name, " po00"}, po00, $signed(e[0]));
        check({name, " po01"}, po01, $signed(e[1]));
        check({name, " po10"}, po10, $signed(e[2]));
        check({name, " po11"}, po11, $signed(e[3]));
        check({name, " in_ready in OUT"}, in_ready, 0);
    endtask

    task automatic checkRelease(input string name);
        @(posedge clk);
        #1;
        check({name, " out_valid drop"}, out_valid, 0);
        check({name, " in_ready after transfer"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        bit sawValid;

        vecs[0].name = "identity";
        vecs[0].f = m4(256, 0, 0, 256);   vecs[0].p = m4(384, 256, -128, 512);
        vecs[0].q = m4(0, 0, 0, 0);       vecs[0].e = m4(384, 256, -128, 512);
        vecs[1].name = "shear";
        vecs[1].f = m4(256, 256, 0, 256); vecs[1].p = m4(256, 0, 0, 256);
        vecs[1].q = m4(26, 0, 0, 26);     vecs[1].e = m4(538, 256, 256, 282);
        vecs[2].name = "sat_pos";
        vecs[2].f = m4(2048, 0, 0, 2048); vecs[2].p = m4(2048, 0, 0, 2048);
        vecs[2].q = m4(0, 0, 0, 0);       vecs[2].e = m4(32767, 0, 0, 32767);
        vecs[3].name = "sat_neg";
        vecs[3].f = m4(2048, 0, 0, 2048); vecs[3].p = m4(-2048, 0, 0, -2048);
        vecs[3].q = m4(0, 0, 0, 0);       vecs[3].e = m4(-32768, 0, 0, -32768);
        vecs[4].name = "floor";
        vecs[4].f = m4(128, 0, 0, 128);   vecs[4].p = m4(-1, 0, 0, 1);
        vecs[4].q = m4(0, 0, 0, 0);       vecs[4].e = m4(-1, 0, 0, 0);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        driveOperands(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset po00", po00, 0);
        check("reset po11", po11, 0);
        check("reset in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready after reset release", in_ready, 1);

        for (int n = 0; n < 5; n++) begin
            applyStimulus(vecs[n], 1'b1, lat);
            checkOutput(vecs[n].name, vecs[n].e);
            checkRelease(vecs[n].name);
        end

        $display("[TB] backpressure sequence");
        out_ready = 1'b0;
        applyStimulus(vecs[0], 1'b1, lat);
        checkOutput("bp first", vecs[0].e);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            driveOperands(vecs[1]);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp held out_valid", out_valid, 1);
            check("bp held po01", po01, 256);
            check("bp held po10", po10, -128);
            check("bp held in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        checkRelease("bp release");
        applyStimulus(vecs[1], 1'b1, lat);
        checkOutput("bp second", vecs[1].e);
        checkRelease("bp second");

        $display("[TB] reset during computation");
        applyStimulus(vecs[2], 1'b0, lat);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        driveOperands(vecs[4]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst po00", po00, 0);
        check("midrst po11", po11, 0);
        check("midrst in_ready during rst", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst in_ready after release", in_ready, 1);
        sawValid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        check("midrst no stray result", sawValid, 0);
        applyStimulus(vecs[1], 1'b1, lat);
        checkOutput("after midrst", vecs[1].e);
        checkRelease("after midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
